rr_mux_demux_arb: RTL and testbench

- Round-robin arbiter that shares one downstream channel between NUM_REQ requesters.
- An N:1 mux, steered by the registered grant, forwards the winner's request data downstream. A 1:N demux steers the single response back to the same requester.
- Only one transaction is outstanding at a time (request, then response). The block sits between the requester-side valid/ready ports and the shared channel.

---
 rtl/rr_mux_demux_arb_if.sv | 40 ++++
 rtl/rr_mux_demux_arb.sv | 177 +++++++++++++++++
 tb/tb_rr_mux_demux_arb.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_demux_arb_if.sv
// Requester/shared-channel bundle for rr_mux_demux_arb.
// The slave modport is the arbiter's view. The master modport is the view of the
// environment that drives the requesters and the shared channel.
interface rr_mux_demux_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int SEL_W = $clog2(NUM_REQ);

  // Requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  // Shared downstream channel
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_ready;
  logic                      rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  // Demuxed response and status
  logic [NUM_REQ-1:0]        rsp_valid_out;
  logic [DATA_W-1:0]         rsp_data_out;
  logic                      busy;
  logic                      timeout_err;

  modport slave (
    input  req_valid, req_data, out_ready, rsp_valid, rsp_data,
    output req_ready, out_valid, out_data, out_sel,
           rsp_valid_out, rsp_data_out, busy, timeout_err
  );

  modport master (
    output req_valid, req_data, out_ready, rsp_valid, rsp_data,
    input  req_ready, out_valid, out_data, out_sel,
           rsp_valid_out, rsp_data_out, busy, timeout_err
  );
endinterface

// File: rtl/rr_mux_demux_arb.sv
// Round-robin arbiter with an N:1 request mux and a 1:N response demux over a
// single shared channel. Only one transaction is outstanding at a time.
//
// Optional feature: define RR_ARB_TIMEOUT_EN to add a response timeout of
// TIMEOUT_CYC cycles. A timeout raises a one-cycle timeout_err pulse and abandons
// the transaction. Without the macro, WAIT_RSP waits indefinitely and
// timeout_err is constant 0.
//
// Handshake semantics: a request beat transfers on a rising edge where
// out_valid && out_ready, which is also the edge where req_ready[grant] is high.
// out_valid is held, with stable out_data, until that edge. rsp_valid is a
// single-cycle pulse. It is only honoured in WAIT_RSP and is never back-pressured.
module rr_mux_demux_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_demux_arb_if.slave    bus,
  output logic [1:0]           dbg_state_o
);
  localparam int SEL_W = $clog2(NUM_REQ);

  // Reject unsupported configurations at elaboration time.
  if (!(NUM_REQ == 2 || NUM_REQ == 4 || NUM_REQ == 8) || TIMEOUT_CYC < 2) begin : g_param_check
    $error("rr_mux_demux_arb: NUM_REQ must be 2, 4 or 8 and TIMEOUT_CYC >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_XFER     = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]  rsp_vo_q, rsp_vo_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                timeout_q, timeout_d;

  logic                arb_found;
  logic [SEL_W-1:0]    arb_idx;
  logic [SEL_W-1:0]    scan_idx;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  // Round-robin pick: first set req_valid scanning from ptr upward with wrap.
  // The loop runs from the farthest offset down so the nearest hit is kept.
  // NUM_REQ is a power of two, so the SEL_W-bit add wraps modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx = ptr_q + SEL_W'(i);
      if (bus.req_valid[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  // Next-state logic: arbitration, transfer handshake, response capture and timeout.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    rsp_vo_d   = '0;
    rsp_data_d = rsp_data_q;
    timeout_d  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // out_valid is always high in XFER, so out_ready alone completes the beat.
        if (bus.out_ready) begin
          state_d = S_WAIT_RSP;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT_RSP: begin
        if (bus.rsp_valid) begin
          // A response arriving on the timeout cycle still wins.
          rsp_vo_d   = NUM_REQ'(1) << grant_q;
          rsp_data_d = bus.rsp_data;
          ptr_d      = grant_q + SEL_W'(1);
          state_d    = S_IDLE;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          ptr_d     = grant_q + SEL_W'(1);
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. An asynchronous reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      rsp_vo_q   <= '0;
      rsp_data_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      rsp_vo_q   <= rsp_vo_d;
      rsp_data_q <= rsp_data_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Response wait counter, cleared on entry to WAIT_RSP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Output decode: the request mux and req_ready follow the latched grant in XFER only.
  always_comb begin
    bus.out_valid = (state_q == S_XFER);
    bus.out_sel   = grant_q;
    bus.out_data  = '0;
    bus.req_ready = '0;
    if (state_q == S_XFER) begin
      bus.out_data = bus.req_data[grant_q * DATA_W +: DATA_W];
      if (bus.out_ready) begin
        bus.req_ready = NUM_REQ'(1) << grant_q;
      end
    end
    bus.busy          = (state_q != S_IDLE);
    bus.rsp_valid_out = rsp_vo_q;
    bus.rsp_data_out  = rsp_data_q;
`ifdef RR_ARB_TIMEOUT_EN
    bus.timeout_err   = timeout_q;
`else
    bus.timeout_err   = 1'b0;
`endif
    dbg_state_o       = state_q;
  end

`ifndef RR_ARB_TIMEOUT_EN
  // The timeout register is driven to 0 and kept only so both builds share one register block.
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif
endmodule

// File: tb/tb_rr_mux_demux_arb.sv
// Directed testbench for rr_mux_demux_arb (NUM_REQ=4, DATA_W=8, TIMEOUT_CYC=16).
module tb_rr_mux_demux_arb;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int checks;
  int failures;

  rr_mux_demux_arb_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  rr_mux_demux_arb #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so sampling is away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full transaction from IDLE with req_valid already driven: arbitrate,
  // accept immediately and answer immediately.
  task automatic do_txn(input int g, input logic [7:0] exp_data, input logic [7:0] rsp);
    tick();
    check("txn_state_xfer", 32'(dbg_state), 32'd1);
    check("txn_out_valid", 32'(bus.out_valid), 32'd1);
    check("txn_out_sel", 32'(bus.out_sel), 32'(g));
    check("txn_out_data", 32'(bus.out_data), 32'(exp_data));
    check("txn_req_ready", 32'(bus.req_ready), 32'(1) << g);
    tick();
    check("txn_wait_out_valid", 32'(bus.out_valid), 32'd0);
    check("txn_wait_busy", 32'(bus.busy), 32'd1);
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = rsp;
    tick();
    bus.rsp_valid = 1'b0;
    check("txn_rsp_valid_out", 32'(bus.rsp_valid_out), 32'(1) << g);
    check("txn_rsp_data_out", 32'(bus.rsp_data_out), 32'(rsp));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid_out", 32'(bus.rsp_valid_out), 32'd0);
    check("rst_rsp_data_out", 32'(bus.rsp_data_out), 32'd0);
    check("rst_out_sel", 32'(bus.out_sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    tick();
    rst_n = 1'b1;

    // Single requester 2
    bus.req_valid = 4'b0100;
    bus.req_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.out_ready = 1'b1;
    do_txn(2, 8'hA5, 8'h3C);
    check("single_busy_after", 32'(bus.busy), 32'd0);
    bus.req_valid = '0;
    tick();
    check("single_rsp_pulse_end", 32'(bus.rsp_valid_out), 32'd0);
    check("single_rsp_data_hold", 32'(bus.rsp_data_out), 32'h3C);

    // Wrap and skip: ptr=3, requesters 0 and 1 active
    bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req_valid = 4'b0011;
    do_txn(0, 8'h11, 8'h51);
    do_txn(1, 8'h22, 8'h52);
    bus.req_valid = '0;

    // rsp_valid in IDLE is ignored
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 8'hEE;
    tick();
    bus.rsp_valid = 1'b0;
    check("idle_rsp_ignored_vo", 32'(bus.rsp_valid_out), 32'd0);
    check("idle_rsp_ignored_data", 32'(bus.rsp_data_out), 32'h52);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Backpressure: ptr=2, only requester 0 active, out_ready low 5 cycles
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    tick();
    check("bp_out_sel", 32'(bus.out_sel), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.rsp_valid = (i == 2);
      tick();
      bus.rsp_valid = 1'b0;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data", 32'(bus.out_data), 32'h11);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_state_xfer", 32'(dbg_state), 32'd1);
    end
    check("bp_xfer_rsp_ignored", 32'(bus.rsp_valid_out), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    check("bp_req_ready_release", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = '0;
    check("bp_state_wait", 32'(dbg_state), 32'd2);
    check("bp_wait_out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid WAIT_RSP
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_rsp_data_out", 32'(bus.rsp_data_out), 32'd0);
    check("mid_rst_out_sel", 32'(bus.out_sel), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst_n = 1'b1;

    // Round robin from ptr=0 with all requesters active
    bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.req_valid = 4'b1111;
    do_txn(0, 8'hA0, 8'h60);
    do_txn(1, 8'hB1, 8'h61);
    do_txn(2, 8'hC2, 8'h62);
    do_txn(3, 8'hD3, 8'h63);
    do_txn(0, 8'hA0, 8'h64);

    // Response wait with no response: ptr=1, requester 1 active
    bus.req_valid = 4'b0010;
    tick();
    check("to_out_sel", 32'(bus.out_sel), 32'd1);
    tick();
    bus.req_valid = '0;
    check("to_state_wait", 32'(dbg_state), 32'd2);
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      tick();
      check("to_no_err_yet", 32'(bus.timeout_err), 32'd0);
    end
    tick();
    check("to_err_pulse", 32'(bus.timeout_err), 32'd1);
    check("to_rsp_vo_zero", 32'(bus.rsp_valid_out), 32'd0);
    check("to_busy_clear", 32'(bus.busy), 32'd0);
    bus.req_valid = 4'b1111;
    tick();
    check("to_err_end", 32'(bus.timeout_err), 32'd0);
    check("to_next_grant", 32'(bus.out_sel), 32'd2);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("wait_no_err", 32'(bus.timeout_err), 32'd0);
      check("wait_busy", 32'(bus.busy), 32'd1);
    end
    bus.rsp_valid = 1'b1;
    bus.rsp_data  = 8'h77;
    tick();
    bus.rsp_valid = 1'b0;
    check("late_rsp_vo", 32'(bus.rsp_valid_out), 32'b0010);
    check("late_rsp_data", 32'(bus.rsp_data_out), 32'h77);
    bus.req_valid = 4'b1111;
    tick();
    check("late_next_grant", 32'(bus.out_sel), 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
